// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bus between the fetch unit and the controller
//
// Purpose: groups every non-clock, non-reset signal of fetch_ctrl.
// Ports (as seen from the controller, modport slave):
//   Start      in   single-cycle (re)launch request
//   PC         in   current fetch address
//   Instr      in   instruction word at PC, same cycle
//   Zero       in   ALU zero flag for BZ
//   Init       out  force fetch PC to 0
//   Halt       out  freeze fetch PC
//   Branch     out  branch taken this cycle
//   Target     out  signed PC offset (next PC = PC + Target + 1)
//   Done       out  registered, high while halted
//   CycleCount out  RUN-cycle count of the current program
// The master modport is the fetch-unit / stimulus side.
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             Start;
  logic [7:0]       PC;
  logic [8:0]       Instr;
  logic             Zero;
  logic             Init;
  logic             Halt;
  logic             Branch;
  logic [7:0]       Target;
  logic             Done;
  logic [CNT_W-1:0] CycleCount;

  modport master (
    output Start, PC, Instr, Zero,
    input  Init, Halt, Branch, Target, Done, CycleCount
  );

  modport slave (
    input  Start, PC, Instr, Zero,
    output Init, Halt, Branch, Target, Done, CycleCount
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - program sequencing controller for a simple fetch unit
//
// Purpose: four-state FSM (IDLE, LAUNCH, RUN, HALTED) that launches a program
// from PC 0, decodes branch/halt opcodes while running, stops before the PC
// can wrap through sequential fetch, and counts RUN cycles.
// Ports:
//   CLK    in  clock, all state on rising edge
//   Reset  in  synchronous active-high reset
//   bus    fetch_ctrl_if.slave (Start, PC, Instr, Zero in;
//          Init, Halt, Branch, Target, Done, CycleCount out)
module fetch_ctrl #(
  parameter logic [8:0] HALT_OP = 9'h1FF,
  parameter int         CNT_W   = 16
) (
  input logic         CLK,
  input logic         Reset,
  fetch_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       eff_state;
  logic [CNT_W-1:0] cycle_cnt;
  logic             done_q;

  logic             is_halt_op;
  logic             br_taken;
  logic             halt_c;
  logic             init_c;
  logic [7:0]       target_c;

  // While Reset is held the outputs already look like IDLE, so the fetch
  // unit sees Init and no stale Halt/Branch from the interrupted program.
  assign eff_state  = Reset ? S_IDLE : state;
  assign is_halt_op = (bus.Instr == HALT_OP);

  always_comb begin
    br_taken  = 1'b0;
    halt_c    = 1'b0;
    init_c    = 1'b0;
    target_c  = 8'h00;
    state_nxt = state;
    case (eff_state)
      S_IDLE: begin
        init_c = 1'b1;
        if (bus.Start) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        init_c    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.Instr[8:6] == 3'b110)
          br_taken = bus.Zero;
        else if (bus.Instr[8:6] == 3'b111 && !is_halt_op)
          br_taken = 1'b1;
        if (br_taken)
          target_c = {{2{bus.Instr[5]}}, bus.Instr[5:0]};
        // A taken branch at 8'hFF is allowed to wrap; only sequential
        // fetch past the top of memory is stopped.
        halt_c = is_halt_op || (bus.PC == 8'hFF && !br_taken);
        if (halt_c) state_nxt = S_HALTED;
      end
      default: begin
        halt_c = 1'b1;
        if (bus.Start) state_nxt = S_LAUNCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= S_IDLE;
      cycle_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state_nxt == S_HALTED);
      if (state == S_LAUNCH)
        cycle_cnt <= '0;
      else if (state == S_RUN && cycle_cnt != CNT_MAX)
        cycle_cnt <= cycle_cnt + CNT_ONE;
    end
  end

  assign bus.Init       = init_c;
  assign bus.Halt       = halt_c;
  assign bus.Branch     = br_taken;
  assign bus.Target     = target_c;
  assign bus.Done       = done_q;
  assign bus.CycleCount = cycle_cnt;

endmodule
